// File: rtl/rocc_axis_bridge_pkg.sv
// Shared definitions for the RoCC <-> AXI-stream HLS bridge: funct
// encodings, controller state encoding and the word-count helper.
package rocc_axis_bridge_pkg;

    localparam logic [6:0] F_PUSH   = 7'd0;
    localparam logic [6:0] F_FIRE   = 7'd1;
    localparam logic [6:0] F_READ   = 7'd2;
    localparam logic [6:0] F_STATUS = 7'd3;
    localparam logic [6:0] F_CYCLES = 7'd4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_OUT = 2'd2,
        RESP     = 2'd3
    } bridge_state_t;

    // Number of xlen-bit words needed to hold a w-bit vector (ceil division).
    function automatic int words(input int w, input int xlen);
        return (w + xlen - 1) / xlen;
    endfunction

endpackage

// File: rtl/rocc_axis_bridge_buf.sv
// Word-write / wide-load / wide-read register array. Storage is WORDS
// xlen-bit words with word 0 in the LSBs; the wide view is truncated to W
// bits. A wide load zero-extends, so any padding in the top word reads 0.
module rocc_axis_bridge_buf #(
    parameter int XLEN  = 64,
    parameter int WORDS = 3,
    parameter int W     = 192,
    parameter int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_idx,
    input  logic [XLEN-1:0] wr_data,
    input  logic            ld_en,
    input  logic [W-1:0]    ld_data,
    output logic [W-1:0]    data
);

    logic [WORDS*XLEN-1:0] mem_r;
    logic [WORDS*XLEN-1:0] ld_ext_s;
    logic                  unused_pad_s;

    // Zero-extend the wide load value to the full word-aligned storage.
    always_comb begin
        ld_ext_s        = '0;
        ld_ext_s[W-1:0] = ld_data;
    end

    // Storage: wide load has priority over a single-word write.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            mem_r <= '0;
        end else if (ld_en) begin
            mem_r <= ld_ext_s;
        end else if (wr_en) begin
            for (int i = 0; i < WORDS; i++) begin
                if (wr_idx == AW'(i)) begin
                    mem_r[i*XLEN +: XLEN] <= wr_data;
                end
            end
        end else begin
            mem_r <= mem_r;
        end
    end

    assign data = mem_r[W-1:0];

    // Padding bits above W in the top word are never read out.
    assign unused_pad_s = ^mem_r;

endmodule

// File: rtl/rocc_axis_bridge.sv
// RoCC command/response to HLS ap_ctrl_hs + AXI-stream bridge.
// Software PUSHes xlen-bit words into a wide input buffer, FIREs one
// accelerator transaction, then READs the captured wide result per word.
// Optional feature macro: ROCC_AXIS_BRIDGE_CYCLE_COUNT_EN adds a 32-bit
// start-to-ap_done cycle counter readable with funct CYCLES.
module rocc_axis_bridge
    import rocc_axis_bridge_pkg::*;
#(
    parameter int IN_W  = 192,
    parameter int OUT_W = 128,
    parameter int XLEN  = 64
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [6:0]       cmd_funct,
    input  logic [XLEN-1:0]  cmd_rs1,
    input  logic [4:0]       cmd_rd,
    input  logic             cmd_xd,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [4:0]       resp_rd,
    output logic [XLEN-1:0]  resp_data,
    output logic             busy,
    output logic             err,
    output logic             ap_start,
    input  logic             ap_done,
    input  logic             ap_idle,
    input  logic             ap_ready,
    output logic             in_tvalid,
    input  logic             in_tready,
    output logic [IN_W-1:0]  in_tdata,
    input  logic             out_tvalid,
    output logic             out_tready,
    input  logic [OUT_W-1:0] out_tdata
);

    localparam int IN_WORDS  = words(IN_W, XLEN);
    localparam int OUT_WORDS = words(OUT_W, XLEN);
    localparam int IN_AW     = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1;
    localparam int OUT_AW    = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

    bridge_state_t state_r;
    bridge_state_t next_state_s;

    logic            cmd_ready_r;
    logic            in_tvalid_r;
    logic            ap_start_r;
    logic            out_tready_r;
    logic            resp_valid_r;
    logic [4:0]      resp_rd_r;
    logic [XLEN-1:0] resp_data_r;
    logic            err_r;
    logic [IN_AW-1:0] wptr_r;
    logic [IN_AW-1:0] wptr_next_s;
    logic            sent_r;
    logic            started_r;
    logic            fire_xd_r;
    logic [4:0]      fire_rd_r;

    logic cmd_fire_s;
    logic fire_accept_s;
    logic push_s;
    logic in_fire_s;
    logic ap_rdy_s;
    logic send_done_s;
    logic out_fire_s;
    logic unknown_s;

    logic [XLEN-1:0]           cmd_data_s;
    logic [XLEN-1:0]           rd_idx_s;
    logic [XLEN-1:0]           rd_word_s;
    logic [OUT_WORDS*XLEN-1:0] obuf_pad_s;
    logic [IN_W-1:0]           ibuf_data_s;
    logic [OUT_W-1:0]          obuf_data_s;

`ifdef ROCC_AXIS_BRIDGE_CYCLE_COUNT_EN
    logic [31:0] cyc_cnt_r;
    logic        cyc_run_r;
`else
    logic        unused_done_s;
`endif

    // cmd_ready is only ever high in IDLE, so an accepted command is always an IDLE command.
    assign cmd_fire_s    = cmd_valid && cmd_ready_r;
    assign fire_accept_s = cmd_fire_s && (cmd_funct == F_FIRE);
    assign push_s        = cmd_fire_s && (cmd_funct == F_PUSH);
    assign in_fire_s     = in_tvalid_r && in_tready;
    assign ap_rdy_s      = ap_start_r && ap_ready;
    // Input beat and ap_ready may land in either order or together.
    assign send_done_s   = (sent_r || in_fire_s) && (started_r || ap_rdy_s);
    assign out_fire_s    = out_tready_r && out_tvalid;
    assign rd_idx_s      = cmd_rs1 % XLEN'(OUT_WORDS);

    rocc_axis_bridge_buf #(
        .XLEN  (XLEN),
        .WORDS (IN_WORDS),
        .W     (IN_W),
        .AW    (IN_AW)
    ) u_ibuf (
        .clock   (clock),
        .resetn  (resetn),
        .wr_en   (push_s),
        .wr_idx  (wptr_r),
        .wr_data (cmd_rs1),
        .ld_en   (1'b0),
        .ld_data ({IN_W{1'b0}}),
        .data    (ibuf_data_s)
    );

    rocc_axis_bridge_buf #(
        .XLEN  (XLEN),
        .WORDS (OUT_WORDS),
        .W     (OUT_W),
        .AW    (OUT_AW)
    ) u_obuf (
        .clock   (clock),
        .resetn  (resetn),
        .wr_en   (1'b0),
        .wr_idx  ({OUT_AW{1'b0}}),
        .wr_data ({XLEN{1'b0}}),
        .ld_en   (out_fire_s),
        .ld_data (out_tdata),
        .data    (obuf_data_s)
    );

    // Write pointer advance with wrap at the last input word.
    always_comb begin
        if (wptr_r == IN_AW'(IN_WORDS - 1)) begin
            wptr_next_s = '0;
        end else begin
            wptr_next_s = wptr_r + {{(IN_AW-1){1'b0}}, 1'b1};
        end
    end

    // Select the requested output word; the top word is zero-padded.
    always_comb begin
        obuf_pad_s            = '0;
        obuf_pad_s[OUT_W-1:0] = obuf_data_s;
        rd_word_s             = '0;
        for (int i = 0; i < OUT_WORDS; i++) begin
            if (rd_idx_s == XLEN'(i)) begin
                rd_word_s = obuf_pad_s[i*XLEN +: XLEN];
            end else begin
                rd_word_s = rd_word_s;
            end
        end
    end

    // Decode the funct into response data and the unknown-funct flag.
    always_comb begin
        unknown_s  = 1'b0;
        cmd_data_s = '0;
        case (cmd_funct)
            F_PUSH:   cmd_data_s[IN_AW-1:0] = wptr_next_s;
            F_FIRE:   cmd_data_s = '0;
            F_READ:   cmd_data_s = rd_word_s;
            F_STATUS: cmd_data_s[IN_AW+1:0] = {wptr_r, err_r, ap_idle};
`ifdef ROCC_AXIS_BRIDGE_CYCLE_COUNT_EN
            F_CYCLES: cmd_data_s[31:0] = cyc_cnt_r;
`endif
            default: begin
                unknown_s  = 1'b1;
                cmd_data_s = '1;
            end
        endcase
    end

    // Next-state logic for IDLE -> SEND -> WAIT_OUT -> RESP -> IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!cmd_fire_s) begin
                    next_state_s = IDLE;
                end else if (cmd_funct == F_FIRE) begin
                    next_state_s = SEND;
                end else if (cmd_xd) begin
                    next_state_s = RESP;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SEND: begin
                if (send_done_s) begin
                    next_state_s = WAIT_OUT;
                end else begin
                    next_state_s = SEND;
                end
            end
            WAIT_OUT: begin
                if (!out_fire_s) begin
                    next_state_s = WAIT_OUT;
                end else if (fire_xd_r) begin
                    next_state_s = RESP;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered handshakes, response fields, write pointer and sticky error.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cmd_ready_r  <= 1'b0;
            in_tvalid_r  <= 1'b0;
            ap_start_r   <= 1'b0;
            out_tready_r <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_rd_r    <= 5'd0;
            resp_data_r  <= '0;
            err_r        <= 1'b0;
            wptr_r       <= '0;
            sent_r       <= 1'b0;
            started_r    <= 1'b0;
            fire_xd_r    <= 1'b0;
            fire_rd_r    <= 5'd0;
        end else begin
            cmd_ready_r <= (next_state_s == IDLE);
            case (state_r)
                IDLE: begin
                    if (cmd_fire_s) begin
                        if (cmd_funct == F_FIRE) begin
                            in_tvalid_r <= 1'b1;
                            ap_start_r  <= 1'b1;
                            sent_r      <= 1'b0;
                            started_r   <= 1'b0;
                            fire_xd_r   <= cmd_xd;
                            fire_rd_r   <= cmd_rd;
                        end else if (cmd_xd) begin
                            resp_valid_r <= 1'b1;
                            resp_rd_r    <= cmd_rd;
                            resp_data_r  <= cmd_data_s;
                        end
                        if (unknown_s) begin
                            err_r <= 1'b1;
                        end
                        if (push_s) begin
                            wptr_r <= wptr_next_s;
                        end
                    end
                end
                SEND: begin
                    if (in_fire_s) begin
                        in_tvalid_r <= 1'b0;
                        sent_r      <= 1'b1;
                    end
                    if (ap_rdy_s) begin
                        ap_start_r <= 1'b0;
                        started_r  <= 1'b1;
                    end
                    if (send_done_s) begin
                        out_tready_r <= 1'b1;
                    end
                end
                WAIT_OUT: begin
                    if (out_fire_s) begin
                        out_tready_r <= 1'b0;
                        wptr_r       <= '0;
                        if (fire_xd_r) begin
                            resp_valid_r <= 1'b1;
                            resp_rd_r    <= fire_rd_r;
                            resp_data_r  <= '0;
                        end
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                    end
                end
                default: begin
                    in_tvalid_r  <= 1'b0;
                    ap_start_r   <= 1'b0;
                    out_tready_r <= 1'b0;
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef ROCC_AXIS_BRIDGE_CYCLE_COUNT_EN
    // Cycle counter: cleared on FIRE acceptance, counts until ap_done, then freezes.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cyc_cnt_r <= 32'd0;
            cyc_run_r <= 1'b0;
        end else if (fire_accept_s) begin
            cyc_cnt_r <= 32'd0;
            cyc_run_r <= 1'b1;
        end else if (cyc_run_r && ap_done) begin
            cyc_run_r <= 1'b0;
        end else if (cyc_run_r) begin
            cyc_cnt_r <= cyc_cnt_r + 32'd1;
        end else begin
            cyc_cnt_r <= cyc_cnt_r;
        end
    end
`else
    // Without the counter ap_done has no consumer.
    assign unused_done_s = ap_done ^ fire_accept_s;
`endif

    assign cmd_ready  = cmd_ready_r;
    assign in_tvalid  = in_tvalid_r;
    assign ap_start   = ap_start_r;
    assign out_tready = out_tready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rd    = resp_rd_r;
    assign resp_data  = resp_data_r;
    assign busy       = (state_r != IDLE);
    assign err        = err_r;
    assign in_tdata   = ibuf_data_s;

endmodule

// File: tb/tb_rocc_axis_bridge.sv
// Directed self-checking bench for rocc_axis_bridge (default parameters).
// The accelerator side is driven step by step from the stimulus sequence.
module tb_rocc_axis_bridge;

    localparam int IN_W  = 192;
    localparam int OUT_W = 128;
    localparam int XLEN  = 64;

    logic             clock = 1'b0;
    logic             resetn;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [6:0]       cmd_funct;
    logic [XLEN-1:0]  cmd_rs1;
    logic [4:0]       cmd_rd;
    logic             cmd_xd;
    logic             resp_valid;
    logic             resp_ready;
    logic [4:0]       resp_rd;
    logic [XLEN-1:0]  resp_data;
    logic             busy;
    logic             err;
    logic             ap_start;
    logic             ap_done;
    logic             ap_idle;
    logic             ap_ready;
    logic             in_tvalid;
    logic             in_tready;
    logic [IN_W-1:0]  in_tdata;
    logic             out_tvalid;
    logic             out_tready;
    logic [OUT_W-1:0] out_tdata;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    rocc_axis_bridge #(.IN_W(IN_W), .OUT_W(OUT_W), .XLEN(XLEN)) dut (
        .clock(clock), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_funct(cmd_funct),
        .cmd_rs1(cmd_rs1), .cmd_rd(cmd_rd), .cmd_xd(cmd_xd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd(resp_rd),
        .resp_data(resp_data), .busy(busy), .err(err),
        .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command and hold it until accepted (bounded wait).
    task automatic do_cmd(input logic [6:0] f, input logic [63:0] rs1,
                          input logic [4:0] rd, input logic xd);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_funct = f; cmd_rs1 = rs1; cmd_rd = rd; cmd_xd = xd;
        while (cmd_ready !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        check("cmd_accept", cmd_ready, 1);
        tick;
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for a response, check it, then complete the handshake.
    task automatic get_resp(input string tag, input logic [4:0] rd, input logic [63:0] data);
        int n;
        n = 0;
        while (resp_valid !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        check({tag, "_valid"}, resp_valid, 1);
        check({tag, "_rd"}, resp_rd, rd);
        check({tag, "_data"}, resp_data, data);
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
        check({tag, "_drop"}, resp_valid, 0);
    endtask

    initial begin
        logic [IN_W-1:0] exp_in;

        resetn = 1'b0; cmd_valid = 1'b0; cmd_funct = 7'd0; cmd_rs1 = 64'd0;
        cmd_rd = 5'd0; cmd_xd = 1'b0; resp_ready = 1'b0; ap_done = 1'b0;
        ap_idle = 1'b1; ap_ready = 1'b0; in_tready = 1'b0; out_tvalid = 1'b0;
        out_tdata = '0;

        // Reset state
        repeat (3) tick;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_in_tvalid", in_tvalid, 0);
        check("rst_ap_start", ap_start, 0);
        check("rst_out_tready", out_tready, 0);
        check("rst_in_tdata", in_tdata, 0);
        resetn = 1'b1;
        tick;
        check("post_rst_cmd_ready", cmd_ready, 1);

        // Back-to-back PUSHes without response
        cmd_valid = 1'b1; cmd_funct = 7'd0; cmd_xd = 1'b0; cmd_rd = 5'd0;
        cmd_rs1 = 64'h8899aabbccddeeff; tick;
        check("push_b2b_ready1", cmd_ready, 1);
        cmd_rs1 = 64'h0011223344556677; tick;
        check("push_b2b_ready2", cmd_ready, 1);
        cmd_rs1 = 64'h0123456789abcdef; tick;
        cmd_valid = 1'b0;
        exp_in = 192'h0123456789abcdef_0011223344556677_8899aabbccddeeff;
        check("push_in_tdata", in_tdata, exp_in);

        // Nominal FIRE with a zero-wait accelerator
        in_tready = 1'b1; ap_ready = 1'b1; out_tvalid = 1'b1;
        out_tdata = 128'hdeadbeef_00000001_cafef00d_12345678;
        cmd_valid = 1'b1; cmd_funct = 7'd1; cmd_xd = 1'b1; cmd_rd = 5'd5;
        tick;
        cmd_valid = 1'b0;
        check("fire_in_tvalid", in_tvalid, 1);
        check("fire_ap_start", ap_start, 1);
        check("fire_busy", busy, 1);
        check("fire_cmd_ready", cmd_ready, 0);
        check("fire_in_tdata", in_tdata, exp_in);
        tick;
        check("fire_out_tready", out_tready, 1);
        check("fire_in_tvalid_drop", in_tvalid, 0);
        check("fire_ap_start_drop", ap_start, 0);
        tick;
        check("fire_out_tready_drop", out_tready, 0);
        check("fire_resp_cmd_ready", cmd_ready, 0);
        get_resp("fire", 5'd5, 64'd0);
        in_tready = 1'b0; ap_ready = 1'b0; out_tvalid = 1'b0;

        // Readback with modulo word index
        do_cmd(7'd2, 64'd0, 5'd1, 1'b1);
        get_resp("read0", 5'd1, 64'hcafef00d12345678);
        do_cmd(7'd2, 64'd1, 5'd2, 1'b1);
        get_resp("read1", 5'd2, 64'hdeadbeef00000001);
        do_cmd(7'd2, 64'd3, 5'd3, 1'b1);
        get_resp("read3", 5'd3, 64'hdeadbeef00000001);

        // Wrap of the write pointer and unknown funct
        do_cmd(7'd0, 64'h11, 5'd4, 1'b1);
        get_resp("push_w1", 5'd4, 64'd1);
        do_cmd(7'd0, 64'h22, 5'd4, 1'b1);
        get_resp("push_w2", 5'd4, 64'd2);
        do_cmd(7'd0, 64'h33, 5'd4, 1'b1);
        get_resp("push_w0", 5'd4, 64'd0);
        do_cmd(7'd0, 64'h44, 5'd4, 1'b1);
        get_resp("push_w1b", 5'd4, 64'd1);
        do_cmd(7'd7, 64'd0, 5'd6, 1'b1);
        get_resp("unknown", 5'd6, 64'hffffffffffffffff);
        check("err_sticky", err, 1);
        do_cmd(7'd3, 64'd0, 5'd7, 1'b1);
        get_resp("status_err", 5'd7, 64'h7);

        // Split handshake: ap_ready 5 cycles before in_tready
        exp_in = {64'h33, 64'h22, 64'h44};
        cmd_valid = 1'b1; cmd_funct = 7'd1; cmd_xd = 1'b1; cmd_rd = 5'd9;
        tick;
        cmd_valid = 1'b0;
        check("split_in_tvalid", in_tvalid, 1);
        check("split_ap_start", ap_start, 1);
        ap_ready = 1'b1;
        tick;
        ap_ready = 1'b0;
        check("split_ap_start_drop", ap_start, 0);
        check("split_in_tvalid_hold", in_tvalid, 1);
        for (int i = 0; i < 4; i++) begin
            tick;
            check("split_in_tvalid_wait", in_tvalid, 1);
            check("split_no_wait_out", out_tready, 0);
            check("split_ap_start_low", ap_start, 0);
        end
        check("split_in_tdata", in_tdata, exp_in);
        in_tready = 1'b1;
        tick;
        in_tready = 1'b0;
        check("split_in_tvalid_drop", in_tvalid, 0);
        check("split_out_tready", out_tready, 1);
        out_tvalid = 1'b1;
        out_tdata = 128'h0000000a_0000000b_0000000c_0000000d;
        tick;
        out_tvalid = 1'b0;

        // Response backpressure
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", resp_valid, 1);
            check("bp_rd", resp_rd, 9);
            check("bp_data", resp_data, 0);
            check("bp_cmd_ready", cmd_ready, 0);
            tick;
        end
        get_resp("bp", 5'd9, 64'd0);
        do_cmd(7'd2, 64'd1, 5'd10, 1'b1);
        get_resp("split_read1", 5'd10, 64'h0000000a0000000b);
        do_cmd(7'd3, 64'd0, 5'd11, 1'b1);
        get_resp("status_after_fire", 5'd11, 64'h3);

        // Reset while in WAIT_OUT
        do_cmd(7'd0, 64'h55, 5'd0, 1'b0);
        in_tready = 1'b1; ap_ready = 1'b1;
        cmd_valid = 1'b1; cmd_funct = 7'd1; cmd_xd = 1'b1; cmd_rd = 5'd12;
        tick;
        cmd_valid = 1'b0;
        tick;
        check("wo_out_tready", out_tready, 1);
        check("wo_busy", busy, 1);
        resetn = 1'b0;
        tick;
        in_tready = 1'b0; ap_ready = 1'b0;
        check("mid_rst_cmd_ready", cmd_ready, 0);
        check("mid_rst_out_tready", out_tready, 0);
        check("mid_rst_in_tvalid", in_tvalid, 0);
        check("mid_rst_ap_start", ap_start, 0);
        check("mid_rst_resp_valid", resp_valid, 0);
        check("mid_rst_resp_rd", resp_rd, 0);
        check("mid_rst_resp_data", resp_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_in_tdata", in_tdata, 0);
        resetn = 1'b1;
        tick;
        check("mid_rst_cmd_ready_up", cmd_ready, 1);
        do_cmd(7'd3, 64'd0, 5'd13, 1'b1);
        get_resp("status_wptr0", 5'd13, 64'h1);
        do_cmd(7'd2, 64'd0, 5'd14, 1'b1);
        get_resp("read_obuf_clr", 5'd14, 64'd0);

`ifdef ROCC_AXIS_BRIDGE_CYCLE_COUNT_EN
        // ap_done 7 cycles after ap_start rises
        in_tready = 1'b1; ap_ready = 1'b1; ap_done = 1'b0;
        cmd_valid = 1'b1; cmd_funct = 7'd1; cmd_xd = 1'b1; cmd_rd = 5'd3;
        tick;
        cmd_valid = 1'b0;
        check("cyc_ap_start", ap_start, 1);
        repeat (7) tick;
        ap_done = 1'b1;
        tick;
        ap_done = 1'b0;
        out_tvalid = 1'b1;
        tick;
        out_tvalid = 1'b0; in_tready = 1'b0; ap_ready = 1'b0;
        get_resp("cyc_fire", 5'd3, 64'd0);
        do_cmd(7'd4, 64'd0, 5'd2, 1'b1);
        get_resp("cycles", 5'd2, 64'd7);
        check("cycles_no_err", err, 0);
`else
        // Without the counter funct 4 is unknown
        do_cmd(7'd4, 64'd0, 5'd2, 1'b1);
        get_resp("f4_unknown", 5'd2, 64'hffffffffffffffff);
        check("f4_err", err, 1);
        do_cmd(7'd3, 64'd0, 5'd15, 1'b1);
        get_resp("status_f4", 5'd15, 64'h3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
